iir_sos_coeff_loader: RTL and testbench
=======================================

Name: iir_sos_coeff_loader

Overview:
Writer side of the cascade SOS coefficient interface. It accepts a serial stream of COF_WD-bit coefficient words and sign-extends each word to IIR_WD. Words fill a shadow bank holding b0,b1,b2,a1,a2 for every section. A complete set is committed atomically to the active bank that drives the SOS sections, and only at a sample boundary signalled by the datapath. It sits between the host/config port and the cascade IIR core.

Parameters:
IIR_WD, 48, datapath/coefficient output width
COF_WD, 32, input coefficient word width (signed, two's complement)
IIR_SOS_NUM, 6, number of SOS sections
COF_FRAC, 30, fractional bits of coefficient format (sets unity value for reset)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
s_valid  in  1  coefficient word valid
s_ready  out  1  loader can accept word
s_data  in  COF_WD  signed coefficient word
s_last  in  1  marks final word of a set
swap_ok  in  1  sample boundary; active bank may change at this edge
coef_b  out  IIR_SOS_NUM*3*IIR_WD  active b coeffs; section k (0-based), tap j at [(k*3+j)*IIR_WD +: IIR_WD]
coef_a  out  IIR_SOS_NUM*2*IIR_WD  active a coeffs; section k, tap j (j=0→a1, j=1→a2) at [(k*2+j)*IIR_WD +: IIR_WD]
coef_update  out  1  one-cycle pulse: active bank just changed
pending  out  1  complete set held in shadow, awaiting swap_ok
err  out  1  one-cycle pulse: framing error, set discarded

Behaviour:
- Only clock is clk. Reset is synchronous and active-low on rst_n.
- Set size N = IIR_SOS_NUM*5. Word order: section 0..IIR_SOS_NUM-1; within each section b0,b1,b2,a1,a2.
- Transfer occurs when s_valid && s_ready. s_valid may drop between words with no effect. s_data and s_last are ignored when no transfer occurs.
- Sign extension: stored value = {{(IIR_WD-COF_WD){s_data[COF_WD-1]}}, s_data}. There is no shift or rounding.
- Counters: coef_idx 0..4 and sec_idx 0..IIR_SOS_NUM-1. coef_idx wraps 4→0 and increments sec_idx.
- FSM, 2 states:
  - LOAD: s_ready=1. Each transfer writes shadow[sec_idx][coef_idx] and advances the counters.
  - LOAD → PEND: on a transfer at word N-1 with s_last=1. Counters clear to 0.
  - PEND: s_ready=0, pending=1.
  - PEND → LOAD: on the first cycle with swap_ok=1. The active bank is loaded from the shadow at that edge, and coef_update=1 for the following cycle.
  - Latency: last word accepted at edge t → pending=1 from t+1. With swap_ok=1 at t+1, new coeffs are visible and coef_update=1 from t+2.
- Framing errors (LOAD state only):
  - s_last=1 on a transfer at word index < N-1, or s_last=0 on the transfer at index N-1.
  - Response: err pulses 1 cycle, counters clear to 0, state stays LOAD, active bank is unchanged.
  - The erroneous word is written to the shadow but never committed.
- swap_ok in LOAD has no effect. Active outputs change only on a commit.
- In PEND, s_valid is held off by s_ready=0. No word is lost and none is overwritten.
- Reset values:
  - s_ready=1, pending=0, coef_update=0, err=0, state LOAD, counters 0.
  - Active bank: every b0 = 1<<COF_FRAC sign-extended (unity pass-through); b1, b2, a1, a2 = 0.
  - Shadow bank: same as active.
- Reset mid-load or in PEND: partial or pending set is discarded and all reset values are restored at the next edge.
- Outputs are registered straight from the active bank, with no combinational path from s_* to coef_*.
- Design must close with back-to-back transfers, one word per cycle.

Test Plan:
1. Assert rst_n=0 for 2 cycles, then release → every coef_b b0 = 48'h0000_4000_0000; all other taps 0; s_ready=1; pending=0.
2. Stream 30 words 32'h0000_0001..32'h0000_001E back-to-back, s_last on the 30th, swap_ok=0 → pending=1, s_ready=0, outputs unchanged. Then swap_ok=1 for 1 cycle → next cycle section0 b0=1, section5 a2=30 (0x1E), coef_update high exactly 1 cycle, s_ready=1.
3. First word 32'h8000_0000, second word 32'h7FFF_FFFF, full set committed → section0 b0=48'hFFFF_8000_0000, b1=48'h0000_7FFF_FFFF.
4. s_last=1 on word 10 → err pulses 1 cycle, pending stays 0, outputs unchanged. A following correct 30-word set commits normally. Repeat with s_last=0 on word 30 → err, no pending.
5. Random s_valid gaps, with swap_ok held high before load completes → commit occurs at t+1 after the last word. Words arriving while pending are held, not accepted, until the commit.
6. rst_n=0 after 15 words, and separately while pending=1 → identity coefficients restored, counters 0. A subsequent full load and commit is correct.

Source files
------------

// File: rtl/iir_sos_coeff_loader.sv
// Coefficient loader for the cascaded SOS IIR core.
// Serial coefficient words are sign-extended into a shadow bank. A complete,
// correctly framed set is copied into the active bank in one edge, and only
// when the datapath signals a sample boundary. The sections therefore never
// see a half-updated coefficient set.
module iir_sos_coeff_loader #(
  parameter int IIR_WD      = 48,
  parameter int COF_WD      = 32,
  parameter int IIR_SOS_NUM = 6,
  parameter int COF_FRAC    = 30
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [COF_WD-1:0]               s_data,
  input  logic                            s_last,
  input  logic                            swap_ok,
  output logic [IIR_SOS_NUM*3*IIR_WD-1:0] coef_b,
  output logic [IIR_SOS_NUM*2*IIR_WD-1:0] coef_a,
  output logic                            coef_update,
  output logic                            pending,
  output logic                            err
);

  localparam int SEC_W = (IIR_SOS_NUM > 1) ? $clog2(IIR_SOS_NUM) : 1;
  localparam logic [SEC_W-1:0] LAST_SEC = SEC_W'(IIR_SOS_NUM - 1);
  localparam logic [COF_WD-1:0] UNITY_W = COF_WD'(1) << COF_FRAC;
  localparam logic [IIR_WD-1:0] UNITY = {{(IIR_WD-COF_WD){UNITY_W[COF_WD-1]}}, UNITY_W};

  typedef enum logic {
    LOAD,
    PEND
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       coefIdx_q, coefIdx_d;
  logic [SEC_W-1:0] secIdx_q, secIdx_d;
  logic             coefUpdate_q, coefUpdate_d;
  logic             err_q, err_d;
  logic             commit;
  logic             xfer;
  logic             lastWord;
  logic [IIR_WD-1:0] sxData;

  logic [IIR_WD-1:0] shadowB_q [IIR_SOS_NUM][3];
  logic [IIR_WD-1:0] shadowA_q [IIR_SOS_NUM][2];
  logic [IIR_WD-1:0] activeB_q [IIR_SOS_NUM][3];
  logic [IIR_WD-1:0] activeA_q [IIR_SOS_NUM][2];

  assign s_ready     = (state_q == LOAD);
  assign pending     = (state_q == PEND);
  assign coef_update = coefUpdate_q;
  assign err         = err_q;
  assign xfer        = s_valid && s_ready;
  assign lastWord    = (secIdx_q == LAST_SEC) && (coefIdx_q == 3'd4);
  assign sxData      = {{(IIR_WD-COF_WD){s_data[COF_WD-1]}}, s_data};

  // Next-state logic: word counting, framing check and commit decision.
  always_comb begin
    state_d      = state_q;
    coefIdx_d    = coefIdx_q;
    secIdx_d     = secIdx_q;
    coefUpdate_d = 1'b0;
    err_d        = 1'b0;
    commit       = 1'b0;
    case (state_q)
      LOAD: begin
        if (xfer) begin
          if (s_last != lastWord) begin
            err_d     = 1'b1;
            coefIdx_d = '0;
            secIdx_d  = '0;
          end else if (lastWord) begin
            state_d   = PEND;
            coefIdx_d = '0;
            secIdx_d  = '0;
          end else if (coefIdx_q == 3'd4) begin
            coefIdx_d = '0;
            secIdx_d  = secIdx_q + SEC_W'(1);
          end else begin
            coefIdx_d = coefIdx_q + 3'd1;
          end
        end
      end
      PEND: begin
        if (swap_ok) begin
          state_d      = LOAD;
          commit       = 1'b1;
          coefUpdate_d = 1'b1;
        end
      end
    endcase
  end

  // Control registers: FSM state, word counters and the status pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= LOAD;
      coefIdx_q    <= '0;
      secIdx_q     <= '0;
      coefUpdate_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      coefIdx_q    <= coefIdx_d;
      secIdx_q     <= secIdx_d;
      coefUpdate_q <= coefUpdate_d;
      err_q        <= err_d;
    end
  end

  // Shadow bank: every accepted word lands here, including a misframed one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < IIR_SOS_NUM; k++) begin
        shadowB_q[k][0] <= UNITY;
        shadowB_q[k][1] <= '0;
        shadowB_q[k][2] <= '0;
        shadowA_q[k][0] <= '0;
        shadowA_q[k][1] <= '0;
      end
    end else if (xfer) begin
      case (coefIdx_q)
        3'd0:    shadowB_q[secIdx_q][0] <= sxData;
        3'd1:    shadowB_q[secIdx_q][1] <= sxData;
        3'd2:    shadowB_q[secIdx_q][2] <= sxData;
        3'd3:    shadowA_q[secIdx_q][0] <= sxData;
        3'd4:    shadowA_q[secIdx_q][1] <= sxData;
        default: ;
      endcase
    end
  end

  // Active bank: whole-set copy from the shadow at the sample boundary.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < IIR_SOS_NUM; k++) begin
        activeB_q[k][0] <= UNITY;
        activeB_q[k][1] <= '0;
        activeB_q[k][2] <= '0;
        activeA_q[k][0] <= '0;
        activeA_q[k][1] <= '0;
      end
    end else if (commit) begin
      activeB_q <= shadowB_q;
      activeA_q <= shadowA_q;
    end
  end

  // Flatten the active bank onto the output buses, straight from registers.
  always_comb begin
    coef_b = '0;
    coef_a = '0;
    for (int k = 0; k < IIR_SOS_NUM; k++) begin
      for (int j = 0; j < 3; j++) coef_b[(k*3+j)*IIR_WD +: IIR_WD] = activeB_q[k][j];
      for (int j = 0; j < 2; j++) coef_a[(k*2+j)*IIR_WD +: IIR_WD] = activeA_q[k][j];
    end
  end

endmodule

// File: tb/tb_iir_sos_coeff_loader.sv
// Directed testbench for iir_sos_coeff_loader: reset state, full loads,
// sign extension, framing errors, gapped input with held swap_ok,
// back-pressure while pending, and reset recovery.
module tb_iir_sos_coeff_loader;

  localparam int W   = 48;
  localparam int SOS = 6;
  localparam int N   = SOS * 5;
  localparam int BW  = SOS * 3 * W;
  localparam int AW  = SOS * 2 * W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid;
  logic          s_ready;
  logic [31:0]   s_data;
  logic          s_last;
  logic          swap_ok;
  logic [BW-1:0] coef_b;
  logic [AW-1:0] coef_a;
  logic          coef_update;
  logic          pending;
  logic          err;

  logic [BW-1:0] expB;
  logic [AW-1:0] expA;
  logic [31:0]   setWords [N];
  int            checks   = 0;
  int            failures = 0;
  int            diffIdx;

  iir_sos_coeff_loader #(
    .IIR_WD(W), .COF_WD(32), .IIR_SOS_NUM(SOS), .COF_FRAC(30)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .swap_ok(swap_ok),
    .coef_b(coef_b), .coef_a(coef_a), .coef_update(coef_update),
    .pending(pending), .err(err)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int firstDiff(input logic [BW+AW-1:0] got, input logic [BW+AW-1:0] want);
    for (int i = 0; i < N; i++) if (got[i*W +: W] !== want[i*W +: W]) return i;
    return -1;
  endfunction

  function automatic logic [W-1:0] tapOf(input logic [BW+AW-1:0] v, input int idx);
    if (idx < 0) return '0;
    return v[idx*W +: W];
  endfunction

  task automatic modelIdentity();
    expB = '0;
    expA = '0;
    for (int k = 0; k < SOS; k++) expB[k*3*W +: W] = 48'h0000_4000_0000;
  endtask

  task automatic modelCommit();
    for (int i = 0; i < N; i++) begin
      logic [W-1:0] sx;
      sx = {{16{setWords[i][31]}}, setWords[i]};
      if ((i % 5) < 3) expB[((i/5)*3 + (i%5))*W +: W] = sx;
      else             expA[((i/5)*2 + (i%5) - 3)*W +: W] = sx;
    end
  endtask

  task automatic applyReset(input int cycles);
    s_valid = 1'b0;
    s_last  = 1'b0;
    swap_ok = 1'b0;
    rst_n   = 1'b0;
    repeat (cycles) begin @(posedge clk); #1; end
    rst_n = 1'b1;
  endtask

  task automatic sendWord(input logic [31:0] d, input logic last, input int gap);
    int n;
    s_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    n = 0;
    while (s_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (s_ready !== 1'b1) begin
      checks++; failures++;
      $display("[TB] FAIL send_timeout: s_ready got %b expected 1 within 50 cycles", s_ready);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic sendSet(input int gapMax);
    for (int i = 0; i < N; i++)
      sendWord(setWords[i], (i == N-1), (gapMax > 0) ? int'($urandom_range(0, gapMax)) : 0);
  endtask

  task automatic swapNow();
    swap_ok = 1'b1;
    @(posedge clk); #1;
    swap_ok = 1'b0;
  endtask

  task automatic test_reset();
    applyReset(2);
    modelIdentity();
    checks++;
    if ({coef_a, coef_b} !== {expA, expB}) begin
      failures++; diffIdx = firstDiff({coef_a, coef_b}, {expA, expB});
      $display("[TB] FAIL reset_bank: tap %0d got %h expected %h", diffIdx, tapOf({coef_a, coef_b}, diffIdx), tapOf({expA, expB}, diffIdx));
    end
    checks++; if (coef_b[W-1:0] !== 48'h0000_4000_0000) begin failures++; $display("[TB] FAIL reset_b0: got %h expected 000040000000", coef_b[W-1:0]); end
    checks++; if (s_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready: got %b expected 1", s_ready); end
    checks++; if (pending !== 1'b0) begin failures++; $display("[TB] FAIL reset_pending: got %b expected 0", pending); end
    checks++; if (coef_update !== 1'b0 || err !== 1'b0) begin failures++; $display("[TB] FAIL reset_pulses: update %b err %b expected 0 0", coef_update, err); end
  endtask

  task automatic test_basic_load();
    for (int i = 0; i < N; i++) setWords[i] = 32'(i + 1);
    sendSet(0);
    checks++; if (pending !== 1'b1) begin failures++; $display("[TB] FAIL load_pending: got %b expected 1", pending); end
    checks++; if (s_ready !== 1'b0) begin failures++; $display("[TB] FAIL load_ready: got %b expected 0", s_ready); end
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if ({coef_a, coef_b} !== {expA, expB}) begin
      failures++; diffIdx = firstDiff({coef_a, coef_b}, {expA, expB});
      $display("[TB] FAIL load_unchanged: tap %0d got %h expected %h", diffIdx, tapOf({coef_a, coef_b}, diffIdx), tapOf({expA, expB}, diffIdx));
    end
    checks++; if (pending !== 1'b1 || coef_update !== 1'b0) begin failures++; $display("[TB] FAIL load_wait: pending %b update %b expected 1 0", pending, coef_update); end
    swapNow();
    modelCommit();
    checks++;
    if ({coef_a, coef_b} !== {expA, expB}) begin
      failures++; diffIdx = firstDiff({coef_a, coef_b}, {expA, expB});
      $display("[TB] FAIL load_commit: tap %0d got %h expected %h", diffIdx, tapOf({coef_a, coef_b}, diffIdx), tapOf({expA, expB}, diffIdx));
    end
    checks++; if (coef_b[W-1:0] !== 48'd1) begin failures++; $display("[TB] FAIL load_s0b0: got %h expected 1", coef_b[W-1:0]); end
    checks++; if (coef_a[11*W +: W] !== 48'h1E) begin failures++; $display("[TB] FAIL load_s5a2: got %h expected 1e", coef_a[11*W +: W]); end
    checks++; if (coef_update !== 1'b1) begin failures++; $display("[TB] FAIL load_update: got %b expected 1", coef_update); end
    checks++; if (s_ready !== 1'b1 || pending !== 1'b0) begin failures++; $display("[TB] FAIL load_release: ready %b pending %b expected 1 0", s_ready, pending); end
    @(posedge clk); #1;
    checks++; if (coef_update !== 1'b0) begin failures++; $display("[TB] FAIL load_update_pulse: got %b expected 0", coef_update); end
  endtask

  task automatic test_sign_extend();
    for (int i = 0; i < N; i++) setWords[i] = 32'hF000_0000 | 32'(i);
    setWords[0] = 32'h8000_0000;
    setWords[1] = 32'h7FFF_FFFF;
    sendSet(0);
    swapNow();
    modelCommit();
    checks++; if (coef_b[0 +: W] !== 48'hFFFF_8000_0000) begin failures++; $display("[TB] FAIL sx_min: got %h expected ffff80000000", coef_b[0 +: W]); end
    checks++; if (coef_b[W +: W] !== 48'h0000_7FFF_FFFF) begin failures++; $display("[TB] FAIL sx_max: got %h expected 00007fffffff", coef_b[W +: W]); end
    checks++; if (coef_b[2*W +: W] !== 48'hFFFF_F000_0002) begin failures++; $display("[TB] FAIL sx_neg: got %h expected fffff0000002", coef_b[2*W +: W]); end
    checks++;
    if ({coef_a, coef_b} !== {expA, expB}) begin
      failures++; diffIdx = firstDiff({coef_a, coef_b}, {expA, expB});
      $display("[TB] FAIL sx_bank: tap %0d got %h expected %h", diffIdx, tapOf({coef_a, coef_b}, diffIdx), tapOf({expA, expB}, diffIdx));
    end
  endtask

  task automatic test_framing_err();
    for (int i = 0; i < 10; i++) sendWord(32'hDEAD_0000 + 32'(i), (i == 9), 0);
    checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL early_last_err: got %b expected 1", err); end
    checks++; if (pending !== 1'b0 || s_ready !== 1'b1) begin failures++; $display("[TB] FAIL early_last_state: pending %b ready %b expected 0 1", pending, s_ready); end
    @(posedge clk); #1;
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL early_last_pulse: got %b expected 0", err); end
    swapNow();
    checks++; if (coef_update !== 1'b0) begin failures++; $display("[TB] FAIL swap_in_load: update got %b expected 0", coef_update); end
    checks++;
    if ({coef_a, coef_b} !== {expA, expB}) begin
      failures++; diffIdx = firstDiff({coef_a, coef_b}, {expA, expB});
      $display("[TB] FAIL early_last_bank: tap %0d got %h expected %h", diffIdx, tapOf({coef_a, coef_b}, diffIdx), tapOf({expA, expB}, diffIdx));
    end
    for (int i = 0; i < N; i++) setWords[i] = 32'h0000_0100 + 32'(i);
    sendSet(0);
    checks++; if (pending !== 1'b1) begin failures++; $display("[TB] FAIL recover_pending: got %b expected 1", pending); end
    swapNow();
    modelCommit();
    checks++;
    if ({coef_a, coef_b} !== {expA, expB}) begin
      failures++; diffIdx = firstDiff({coef_a, coef_b}, {expA, expB});
      $display("[TB] FAIL recover_commit: tap %0d got %h expected %h", diffIdx, tapOf({coef_a, coef_b}, diffIdx), tapOf({expA, expB}, diffIdx));
    end
    for (int i = 0; i < N; i++) sendWord(32'h5555_0000 + 32'(i), 1'b0, 0);
    checks++; if (err !== 1'b1 || pending !== 1'b0) begin failures++; $display("[TB] FAIL missing_last: err %b pending %b expected 1 0", err, pending); end
    @(posedge clk); #1;
    checks++; if (pending !== 1'b0 || err !== 1'b0) begin failures++; $display("[TB] FAIL missing_last_after: pending %b err %b expected 0 0", pending, err); end
    checks++;
    if ({coef_a, coef_b} !== {expA, expB}) begin
      failures++; diffIdx = firstDiff({coef_a, coef_b}, {expA, expB});
      $display("[TB] FAIL missing_last_bank: tap %0d got %h expected %h", diffIdx, tapOf({coef_a, coef_b}, diffIdx), tapOf({expA, expB}, diffIdx));
    end
    for (int i = 0; i < N; i++) setWords[i] = 32'h0000_0200 + 32'(i);
    sendSet(0);
    swapNow();
    modelCommit();
    checks++;
    if ({coef_a, coef_b} !== {expA, expB}) begin
      failures++; diffIdx = firstDiff({coef_a, coef_b}, {expA, expB});
      $display("[TB] FAIL recover2_commit: tap %0d got %h expected %h", diffIdx, tapOf({coef_a, coef_b}, diffIdx), tapOf({expA, expB}, diffIdx));
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < N; i++) setWords[i] = 32'hFFFF_FF00 + 32'(i);
    swap_ok = 1'b1;
    sendSet(3);
    checks++; if (pending !== 1'b1 || coef_update !== 1'b0) begin failures++; $display("[TB] FAIL held_swap_pend: pending %b update %b expected 1 0", pending, coef_update); end
    @(posedge clk); #1;
    swap_ok = 1'b0;
    modelCommit();
    checks++; if (pending !== 1'b0 || coef_update !== 1'b1) begin failures++; $display("[TB] FAIL held_swap_commit: pending %b update %b expected 0 1", pending, coef_update); end
    checks++;
    if ({coef_a, coef_b} !== {expA, expB}) begin
      failures++; diffIdx = firstDiff({coef_a, coef_b}, {expA, expB});
      $display("[TB] FAIL held_swap_bank: tap %0d got %h expected %h", diffIdx, tapOf({coef_a, coef_b}, diffIdx), tapOf({expA, expB}, diffIdx));
    end
    for (int i = 0; i < N; i++) setWords[i] = 32'h0000_3000 + 32'(i);
    sendSet(0);
    s_valid = 1'b1;
    s_data  = 32'h0000_4000;
    s_last  = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      checks++; if (s_ready !== 1'b0 || pending !== 1'b1) begin failures++; $display("[TB] FAIL hold_backpressure: ready %b pending %b expected 0 1", s_ready, pending); end
    end
    modelCommit();
    swap_ok = 1'b1;
    @(posedge clk); #1;
    swap_ok = 1'b0;
    checks++; if (coef_update !== 1'b1) begin failures++; $display("[TB] FAIL hold_commit_update: got %b expected 1", coef_update); end
    checks++;
    if ({coef_a, coef_b} !== {expA, expB}) begin
      failures++; diffIdx = firstDiff({coef_a, coef_b}, {expA, expB});
      $display("[TB] FAIL hold_commit_bank: tap %0d got %h expected %h", diffIdx, tapOf({coef_a, coef_b}, diffIdx), tapOf({expA, expB}, diffIdx));
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    for (int i = 0; i < N; i++) setWords[i] = 32'h0000_4000 + 32'(i);
    for (int i = 1; i < N; i++) sendWord(setWords[i], (i == N-1), 0);
    checks++; if (pending !== 1'b1 || err !== 1'b0) begin failures++; $display("[TB] FAIL held_word_set: pending %b err %b expected 1 0", pending, err); end
    swapNow();
    modelCommit();
    checks++;
    if ({coef_a, coef_b} !== {expA, expB}) begin
      failures++; diffIdx = firstDiff({coef_a, coef_b}, {expA, expB});
      $display("[TB] FAIL held_word_bank: tap %0d got %h expected %h", diffIdx, tapOf({coef_a, coef_b}, diffIdx), tapOf({expA, expB}, diffIdx));
    end
  endtask

  task automatic test_reset_recovery();
    for (int i = 0; i < N; i++) setWords[i] = 32'h0000_5000 + 32'(i);
    for (int i = 0; i < 15; i++) sendWord(setWords[i], 1'b0, 0);
    applyReset(1);
    modelIdentity();
    checks++;
    if ({coef_a, coef_b} !== {expA, expB}) begin
      failures++; diffIdx = firstDiff({coef_a, coef_b}, {expA, expB});
      $display("[TB] FAIL midload_reset_bank: tap %0d got %h expected %h", diffIdx, tapOf({coef_a, coef_b}, diffIdx), tapOf({expA, expB}, diffIdx));
    end
    checks++; if (s_ready !== 1'b1 || pending !== 1'b0) begin failures++; $display("[TB] FAIL midload_reset_state: ready %b pending %b expected 1 0", s_ready, pending); end
    sendSet(0);
    swapNow();
    modelCommit();
    checks++;
    if ({coef_a, coef_b} !== {expA, expB}) begin
      failures++; diffIdx = firstDiff({coef_a, coef_b}, {expA, expB});
      $display("[TB] FAIL midload_reload: tap %0d got %h expected %h", diffIdx, tapOf({coef_a, coef_b}, diffIdx), tapOf({expA, expB}, diffIdx));
    end
    for (int i = 0; i < N; i++) setWords[i] = 32'h0000_6000 + 32'(i);
    sendSet(0);
    checks++; if (pending !== 1'b1) begin failures++; $display("[TB] FAIL pend_before_reset: got %b expected 1", pending); end
    applyReset(1);
    modelIdentity();
    checks++;
    if ({coef_a, coef_b} !== {expA, expB}) begin
      failures++; diffIdx = firstDiff({coef_a, coef_b}, {expA, expB});
      $display("[TB] FAIL pend_reset_bank: tap %0d got %h expected %h", diffIdx, tapOf({coef_a, coef_b}, diffIdx), tapOf({expA, expB}, diffIdx));
    end
    checks++; if (pending !== 1'b0 || s_ready !== 1'b1 || coef_update !== 1'b0) begin failures++; $display("[TB] FAIL pend_reset_state: pending %b ready %b update %b expected 0 1 0", pending, s_ready, coef_update); end
    for (int i = 0; i < N; i++) setWords[i] = 32'h0000_7000 + 32'(i);
    sendSet(0);
    swapNow();
    modelCommit();
    checks++;
    if ({coef_a, coef_b} !== {expA, expB}) begin
      failures++; diffIdx = firstDiff({coef_a, coef_b}, {expA, expB});
      $display("[TB] FAIL pend_reset_reload: tap %0d got %h expected %h", diffIdx, tapOf({coef_a, coef_b}, diffIdx), tapOf({expA, expB}, diffIdx));
    end
  endtask

  // Test sequence.
  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    swap_ok = 1'b0;
    test_reset();
    test_basic_load();
    test_sign_extend();
    test_framing_err();
    test_back_to_back();
    test_reset_recovery();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
